// File: rtl/jtag_reg_access_if.sv
// jtag_reg_access_if: debug request/response channel between the debug module and the GPR access sequencer.
interface jtag_reg_access_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    modport master (
        output req_valid, req_we, req_addr, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/jtag_reg_access.sv
// jtag_reg_access: turns debug GPR requests into register-file jtag port cycles, retrying around ex-stage contention.
module jtag_reg_access #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int RETRY_MAX = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    jtag_reg_access_if.slave         dbg,
    input  logic                     ex_we_i,
    input  logic [ADDR_W-1:0]        ex_waddr_i,
    output logic                     reg_we_o,
    output logic [ADDR_W-1:0]        reg_addr_o,
    output logic [DATA_W-1:0]        reg_wdata_o,
    input  logic [DATA_W-1:0]        reg_rdata_i,
    output logic                     busy_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              ready_q, ready_d;
    logic              hazard;
    logic [8:0]        cnt_inc;
    always_comb begin
        // a write loses to any real ex write; a read only to an ex write of the same register
        hazard     = ex_we_i && ((state_q == WRITE) ? (ex_waddr_i != '0) : (ex_waddr_i == addr_q));
        cnt_inc    = {1'b0, cnt_q} + 9'd1;
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: if (dbg.req_valid && ready_q) begin
                addr_d     = dbg.req_addr;
                data_d     = dbg.req_data;
                cnt_d      = '0;
                rsp_data_d = '0;
                rsp_err_d  = 1'b0;
                state_d    = (dbg.req_addr == '0) ? RESP : dbg.req_we ? WRITE : READ;
            end
            WRITE, READ: if (!hazard) begin
                state_d    = RESP;
                rsp_data_d = (state_q == READ) ? reg_rdata_i : '0;
            end else begin
                cnt_d = cnt_inc[8] ? 8'hff : cnt_inc[7:0];
                if (cnt_inc >= 9'(RETRY_MAX)) begin
                    state_d    = RESP;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                end
            end
            default: if (dbg.rsp_ready) state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            ready_q    <= ready_d;
        end
    end
    assign reg_we_o      = (state_q == WRITE);
    assign reg_addr_o    = (state_q == WRITE || state_q == READ) ? addr_q : '0;
    assign reg_wdata_o   = (state_q == WRITE) ? data_q : '0;
    assign busy_o        = (state_q != IDLE);
    assign dbg.req_ready = ready_q;
    assign dbg.rsp_valid = (state_q == RESP);
    assign dbg.rsp_data  = rsp_data_q;
    assign dbg.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_jtag_reg_access.sv
// tb_jtag_reg_access: randomized requests with scheduled ex-stage traffic, checked against a per-transaction reference model.
module tb_jtag_reg_access;
    localparam int RETRY_MAX = 15;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_we = 1'b0;
    logic [4:0]  ex_wa = '0;
    logic [31:0] ex_wd = '0;
    logic        reg_we, busy;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic [31:0] rf  [32];
    logic [31:0] mdl [32];
    logic        sch_we [64];
    logic [4:0]  sch_wa [64];
    logic [31:0] sch_wd [64];
    int n_chk = 0;
    int n_err = 0;
    jtag_reg_access_if bus ();
    jtag_reg_access #(.ADDR_W(5), .DATA_W(32), .RETRY_MAX(RETRY_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .dbg(bus.slave),
        .ex_we_i(ex_we), .ex_waddr_i(ex_wa),
        .reg_we_o(reg_we), .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata),
        .reg_rdata_i(reg_rdata), .busy_o(busy)
    );
    always #5 clk = ~clk;
    // register file environment: ex has priority, x0 reads zero, cleared on reset
    assign reg_rdata = (reg_addr == 0) ? 32'h0 : rf[reg_addr];
    always @(posedge clk) begin
        if (!rst_n) for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        else if (ex_we && ex_wa != 0) rf[ex_wa] <= ex_wd;
        else if (reg_we && reg_addr != 0) rf[reg_addr] <= reg_wdata;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic sch_clr();
        for (int i = 0; i < 64; i++) begin
            sch_we[i] = 1'b0;
            sch_wa[i] = '0;
            sch_wd[i] = '0;
        end
    endtask
    task automatic txn(input logic we, input logic [4:0] a, input logic [31:0] d, input int hold);
        int done, k, lat, nwe, bad, exp_lat, exp_nwe;
        logic hz, exp_err;
        logic [31:0] exp_data;
        done = -1; k = 0; exp_err = 1'b0; exp_data = 32'h0;
        if (a != 0) begin
            for (int i = 0; i < 64 && done < 0; i++) begin
                hz = sch_we[i] && (we ? (sch_wa[i] != 0) : (sch_wa[i] == a));
                if (hz) k++;
                if (!hz || k >= RETRY_MAX) done = i;
                exp_err = hz;
                if (!hz && !we) exp_data = mdl[a];
                if (sch_we[i] && sch_wa[i] != 0) mdl[sch_wa[i]] = sch_wd[i];
                if (!hz && we) mdl[a] = d;
            end
        end
        exp_lat = (a == 0) ? 1 : done + 2;
        exp_nwe = (we && a != 0) ? done + 1 : 0;
        for (int t = 0; t < 8 && !bus.req_ready; t++) @(negedge clk);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_data = d;
        bus.rsp_ready = (hold == 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        nwe = 0; bad = 0;
        for (lat = 1; lat <= 64; lat++) begin
            ex_we = (a != 0 && lat - 1 <= done) ? sch_we[lat-1] : 1'b0;
            ex_wa = sch_wa[lat-1];
            ex_wd = sch_wd[lat-1];
            @(negedge clk);
            if (bus.rsp_valid) break;
            if (reg_we) begin
                nwe++;
                if (reg_addr !== a || reg_wdata !== d) bad++;
            end
            @(posedge clk); #1;
        end
        ex_we = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("we_cycles", 32'(nwe), 32'(exp_nwe));
        chk("we_bus", 32'(bad), 32'd0);
        chk("rsp_data", bus.rsp_data, exp_data);
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        chk("ready_in_resp", 32'(bus.req_ready), 32'd0);
        bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_data || bus.rsp_err !== exp_err ||
                bus.req_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        chk("rsp_hold", 32'(bad), 32'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_done_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rsp_done_ready", 32'(bus.req_ready), 32'd1);
        chk("rsp_done_busy", 32'(busy), 32'd0);
        bus.rsp_ready = 1'b0;
    endtask
    initial begin
        logic [4:0] a;
        logic we;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.rsp_ready = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        sch_clr();
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_we", 32'(reg_we), 32'd0);
        rst_n = 1'b1;
        #1 chk("rdy_before_edge", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("rdy_after_edge", 32'(bus.req_ready), 32'd1);
        txn(1'b1, 5'd5, 32'hDEADBEEF, 0);
        txn(1'b0, 5'd5, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin sch_we[i] = 1'b1; sch_wa[i] = 5'd3; sch_wd[i] = 32'hC3C30003 + i; end
        txn(1'b1, 5'd7, 32'h12345678, 0);
        sch_clr();
        txn(1'b0, 5'd3, 32'h0, 0);
        txn(1'b0, 5'd7, 32'h0, 0);
        for (int i = 0; i < 20; i++) begin sch_we[i] = 1'b1; sch_wa[i] = 5'd3; sch_wd[i] = 32'h33330000 + i; end
        txn(1'b1, 5'd9, 32'hBAD00009, 0);
        sch_clr();
        txn(1'b0, 5'd9, 32'h0, 1);
        txn(1'b1, 5'd4, 32'hA5A5A5A5, 0);
        sch_we[0] = 1'b1; sch_wa[0] = 5'd4; sch_wd[0] = 32'h1;
        txn(1'b0, 5'd4, 32'h0, 0);
        sch_clr();
        txn(1'b1, 5'd0, 32'hFFFFFFFF, 2);
        txn(1'b0, 5'd0, 32'h0, 0);
        txn(1'b1, 5'd12, 32'h0BADF00D, 5);
        // reset while a write is stuck behind contention
        for (int t = 0; t < 8 && !bus.req_ready; t++) @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 5'd9; bus.req_data = 32'h99999999;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; ex_we = 1'b1; ex_wa = 5'd3; ex_wd = 32'h33;
        @(negedge clk);
        chk("mid_write_we", 32'(reg_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", 32'(reg_we), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("async_rst_ready", 32'(bus.req_ready), 32'd0);
        ex_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        @(negedge clk);
        chk("rel_ready", 32'(bus.req_ready), 32'd1);
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            sch_clr();
            if ($urandom_range(0, 2) != 0) begin
                int len;
                len = $urandom_range(1, 20);
                for (int i = 0; i < len; i++) begin
                    sch_we[i] = ($urandom_range(0, 3) != 0);
                    case ($urandom_range(0, 2))
                        0:       sch_wa[i] = 5'd0;
                        1:       sch_wa[i] = a;
                        default: sch_wa[i] = 5'($urandom);
                    endcase
                    sch_wd[i] = $urandom;
                end
            end
            txn(we, a, $urandom, $urandom_range(0, 3));
        end
        for (int i = 1; i < 32; i++) chk($sformatf("rf_x%0d", i), rf[i], mdl[i]);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
